// File: rtl/zbt_pattern_gen_pkg.sv
// Shared definitions for the ZBT pattern generator: pattern mode codes,
// controller state encoding and a counter-width helper.
package zbt_pattern_gen_pkg;

  localparam logic [1:0] ZBT_PAT_CHECKER = 2'd0;
  localparam logic [1:0] ZBT_PAT_SOLID   = 2'd1;
  localparam logic [1:0] ZBT_PAT_GRAD    = 2'd2;
  localparam logic [1:0] ZBT_PAT_ADDR    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } zbt_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zbt_pattern_gen_if.sv
// One ZBT bank port as seen by the pattern generator. The generator drives
// address, write data and write enable; the bank returns read data.
interface zbt_pattern_gen_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write;
  logic              wr;
  logic [DATA_W-1:0] read;

  modport master (output addr, output write, output wr, input read);
  modport slave  (input addr, input write, input wr, output read);
endinterface

// File: rtl/zbt_pattern_gen_word.sv
// Combinational pattern word builder: maps a word position and mode to the
// packed DATA_W word. Pixel 0 sits in the least significant bits.
module zbt_pattern_word
  import zbt_pattern_gen_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 36,
  parameter int PIX_PER_WORD = 2,
  parameter int XW_W         = 9,
  parameter int Y_W          = 9,
  parameter int SQ_LOG2      = 5,
  localparam int PIX_W       = DATA_W / PIX_PER_WORD
) (
  input  logic [XW_W-1:0]   xw,
  input  logic [Y_W-1:0]    y,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  fill,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);

  logic [31:0]      x;
  logic [31:0]      y_ext;
  logic [PIX_W-1:0] pix;

  // Build every pixel of the word; address mode bypasses pixel packing.
  always_comb begin
    word  = '0;
    x     = '0;
    pix   = '0;
    y_ext = 32'(y);
    if (mode == ZBT_PAT_ADDR) begin
      word = DATA_W'(addr);
    end else begin
      for (int p = 0; p < PIX_PER_WORD; p++) begin
        x = 32'(xw) * 32'(PIX_PER_WORD) + 32'(p);
        case (mode)
          ZBT_PAT_CHECKER: pix = {PIX_W{x[SQ_LOG2] ^ y_ext[SQ_LOG2]}};
          ZBT_PAT_SOLID:   pix = fill;
          default:         pix = PIX_W'(x);
        endcase
        word[p*PIX_W +: PIX_W] = pix;
      end
    end
  end

endmodule

// File: rtl/zbt_pattern_gen.sv
// ZBT pattern generator: fills NUM_FRAMES frame buffers on both banks with a
// selectable pattern, optionally reads everything back and counts mismatches.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | banks released; waiting for start
//   ST_WRITE | one word written per cycle to both banks
//   ST_READ  | one read address per cycle, same traversal order
//   ST_FLUSH | READ_LAT+1 cycles so the last read data gets compared
//   ST_DONE  | single cycle before returning to idle with the done pulse
module zbt_pattern_gen
  import zbt_pattern_gen_pkg::*;
#(
  parameter int          ADDR_W       = 19,
  parameter int          DATA_W       = 36,
  parameter int          PIX_PER_WORD = 2,
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          NUM_FRAMES   = 2,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int          SQ_LOG2      = 5,
  parameter int          READ_LAT     = 2,
  localparam int         PIX_W        = DATA_W / PIX_PER_WORD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     verify,
  input  logic [PIX_W-1:0]         fill,
  zbt_pattern_gen_if.master        mem0,
  zbt_pattern_gen_if.master        mem1,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              err_count
);

  localparam int LINE_WORDS = H_ACTIVE / PIX_PER_WORD;
  localparam int XW_W       = cnt_width(LINE_WORDS);
  localparam int Y_W        = cnt_width(V_ACTIVE);
  localparam int F_W        = cnt_width(NUM_FRAMES);
  localparam int FL_W       = cnt_width(READ_LAT + 1);

  localparam logic [XW_W-1:0]   XW_LAST   = XW_W'(LINE_WORDS - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_ACTIVE - 1);
  localparam logic [F_W-1:0]    F_LAST    = F_W'(NUM_FRAMES - 1);
  localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(READ_LAT);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  zbt_state_t state, state_nx;

  logic [XW_W-1:0]   xw, xw_nx;
  logic [Y_W-1:0]    y, y_nx;
  logic [F_W-1:0]    f, f_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [FL_W-1:0]   flush_cnt, flush_nx;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;

  logic issue, wr_nx, cnt_clr, cnt_inc, accept, flush_inc, done_nx, last_word;

  logic [1:0]        mode_q, mode_sel;
  logic              verify_q;
  logic [PIX_W-1:0]  fill_q, fill_sel;

  logic [DATA_W-1:0] wr_word, exp_word;
  logic [DATA_W-1:0] exp_pipe [READ_LAT+1];
  logic [READ_LAT:0] vld_pipe;

  logic              done_q, error_q;
  logic [15:0]       err_cnt_q;
  logic [1:0]        miss;
  logic [16:0]       err_sum;

  // The run ends on counter compares so an address wrap cannot stop it early.
  assign last_word = (xw == XW_LAST) && (y == Y_LAST) && (f == F_LAST);

  // Mode and fill are taken straight from the inputs for the first word,
  // since they are only latched on that same edge.
  assign mode_sel = (state == ST_IDLE) ? mode : mode_q;
  assign fill_sel = (state == ST_IDLE) ? fill : fill_q;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    wr_nx     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    accept    = 1'b0;
    flush_inc = 1'b0;
    done_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_WRITE;
          accept   = 1'b1;
          cnt_clr  = 1'b1;
          issue    = 1'b1;
          wr_nx    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (last_word) begin
          if (verify_q) begin
            state_nx = ST_READ;
            cnt_clr  = 1'b1;
            issue    = 1'b1;
          end else begin
            state_nx = ST_DONE;
          end
        end else begin
          cnt_inc = 1'b1;
          issue   = 1'b1;
          wr_nx   = 1'b1;
        end
      end
      ST_READ: begin
        if (last_word) begin
          state_nx = ST_FLUSH;
        end else begin
          cnt_inc = 1'b1;
          issue   = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FL_LAST) state_nx = ST_DONE;
        else                      flush_inc = 1'b1;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Next traversal position: xw innermost, then y, then frame.
  always_comb begin
    xw_nx    = xw;
    y_nx     = y;
    f_nx     = f;
    addr_nx  = addr_q;
    flush_nx = flush_inc ? flush_cnt + 1'b1 : '0;
    if (cnt_clr) begin
      xw_nx   = '0;
      y_nx    = '0;
      f_nx    = '0;
      addr_nx = ADDR_BASE;
    end else if (cnt_inc) begin
      addr_nx = addr_q + 1'b1;
      if (xw == XW_LAST) begin
        xw_nx = '0;
        if (y == Y_LAST) begin
          y_nx = '0;
          f_nx = f + 1'b1;
        end else begin
          y_nx = y + 1'b1;
        end
      end else begin
        xw_nx = xw + 1'b1;
      end
    end
  end

  zbt_pattern_word #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_PER_WORD(PIX_PER_WORD),
    .XW_W(XW_W), .Y_W(Y_W), .SQ_LOG2(SQ_LOG2)
  ) u_word_wr (
    .xw(xw_nx), .y(y_nx), .mode(mode_sel), .fill(fill_sel), .addr(addr_nx), .word(wr_word)
  );

  zbt_pattern_word #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_PER_WORD(PIX_PER_WORD),
    .XW_W(XW_W), .Y_W(Y_W), .SQ_LOG2(SQ_LOG2)
  ) u_word_exp (
    .xw(xw_nx), .y(y_nx), .mode(mode_sel), .fill(fill_sel), .addr(addr_nx), .word(exp_word)
  );

  // Per-bank mismatch flags for the read data that is valid this cycle.
  always_comb begin
    miss = '0;
    if (vld_pipe[READ_LAT]) begin
      miss[0] = (mem0.read != exp_pipe[READ_LAT]);
      miss[1] = (mem1.read != exp_pipe[READ_LAT]);
    end
    err_sum = {1'b0, err_cnt_q} + 17'(miss[0]) + 17'(miss[1]);
  end

  // Datapath registers: counters, port drivers, expected-data pipeline, error tally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      xw        <= '0;
      y         <= '0;
      f         <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      flush_cnt <= '0;
      done_q    <= 1'b0;
      mode_q    <= '0;
      verify_q  <= 1'b0;
      fill_q    <= '0;
      vld_pipe  <= '0;
      for (int i = 0; i <= READ_LAT; i++) exp_pipe[i] <= '0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      xw        <= xw_nx;
      y         <= y_nx;
      f         <= f_nx;
      addr_q    <= addr_nx;
      wr_q      <= wr_nx;
      wdata_q   <= wr_nx ? wr_word : '0;
      flush_cnt <= flush_nx;
      done_q    <= done_nx;
      if (accept) begin
        mode_q   <= mode;
        verify_q <= verify;
        fill_q   <= fill;
      end
      // Stage 0 lines up with the read address on the port; the last stage
      // lines up with the bank's read data READ_LAT cycles later.
      exp_pipe[0] <= exp_word;
      for (int i = 1; i <= READ_LAT; i++) exp_pipe[i] <= exp_pipe[i-1];
      vld_pipe <= {vld_pipe[READ_LAT-1:0], issue & ~wr_nx};
      if (accept) begin
        error_q   <= 1'b0;
        err_cnt_q <= '0;
      end else if (miss != 2'b00) begin
        error_q   <= 1'b1;
        err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
    end
  end

  assign mem0.addr  = addr_q;
  assign mem1.addr  = addr_q;
  assign mem0.write = wdata_q;
  assign mem1.write = wdata_q;
  assign mem0.wr    = wr_q;
  assign mem1.wr    = wr_q;

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_zbt_pattern_gen.sv
// Bench for zbt_pattern_gen on a small 8x4x2 geometry with a two-bank memory
// model (2-cycle read latency, per-address corruption) and an index-based
// reference model of the pattern, address order and cycle timing.
module tb_zbt_pattern_gen;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;
  localparam int PPW    = 2;
  localparam int H      = 8;
  localparam int V      = 4;
  localparam int NF     = 2;
  localparam int BASE   = 0;
  localparam int SQ     = 1;
  localparam int RL     = 2;
  localparam int PIX_W  = DATA_W / PPW;
  localparam int LW     = H / PPW;
  localparam int FW     = LW * V;
  localparam int N      = FW * NF;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              verify = 1'b0;
  logic [PIX_W-1:0]  fill = '0;
  logic              busy, done, error;
  logic [15:0]       err_count;

  int n_chk = 0;
  int n_pass = 0;

  zbt_pattern_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem0 ();
  zbt_pattern_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem1 ();

  zbt_pattern_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_PER_WORD(PPW), .H_ACTIVE(H),
    .V_ACTIVE(V), .NUM_FRAMES(NF), .BASE_ADDR(BASE), .SQ_LOG2(SQ), .READ_LAT(RL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .verify(verify),
    .fill(fill), .mem0(mem0), .mem1(mem1), .busy(busy), .done(done),
    .error(error), .err_count(err_count)
  );

  always #5 clock = ~clock;

  // Bank model: synchronous write, two-stage read pipeline, optional corruption.
  logic [DATA_W-1:0] bank0 [64];
  logic [DATA_W-1:0] bank1 [64];
  bit                cor0 [64];
  bit                cor1 [64];
  logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b;

  always @(posedge clock) begin
    if (mem0.wr) bank0[mem0.addr[5:0]] <= mem0.write;
    if (mem1.wr) bank1[mem1.addr[5:0]] <= mem1.write;
    r0_a <= bank0[mem0.addr[5:0]] ^ DATA_W'(cor0[mem0.addr[5:0]]);
    r1_a <= bank1[mem1.addr[5:0]] ^ DATA_W'(cor1[mem1.addr[5:0]]);
    r0_b <= r0_a;
    r1_b <= r1_a;
  end
  assign mem0.read = r0_b;
  assign mem1.read = r1_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Expected content of the k-th word written in a run.
  function automatic logic [DATA_W-1:0] model_word(input logic [1:0] m,
                                                   input logic [PIX_W-1:0] fl,
                                                   input int k);
    longint unsigned x, yy, xw, rem;
    logic [PIX_W-1:0]  pix;
    logic [DATA_W-1:0] w;
    w = '0;
    if (m == 2'd3) return DATA_W'((longint'(BASE) + k) % (64'd1 << ADDR_W));
    rem = longint'(k % FW);
    yy  = rem / LW;
    xw  = rem % LW;
    for (int p = 0; p < PPW; p++) begin
      x = xw * PPW + longint'(p);
      case (m)
        2'd0:    pix = ((((x >> SQ) ^ (yy >> SQ)) & 1) != 0) ? '1 : '0;
        2'd1:    pix = fl;
        default: pix = PIX_W'(x);
      endcase
      w = w | (DATA_W'(pix) << (p * PIX_W));
    end
    return w;
  endfunction

  function automatic logic [ADDR_W-1:0] model_addr(input int k);
    return ADDR_W'((longint'(BASE) + k) % (64'd1 << ADDR_W));
  endfunction

  task automatic clear_cor();
    for (int i = 0; i < 64; i++) begin
      cor0[i] = 1'b0;
      cor1[i] = 1'b0;
    end
  endtask

  // One run from the start-sample edge to the done pulse. Called at a negedge
  // with the DUT idle. poke_cyc>0 pulses start (with scrambled inputs) mid-run.
  task automatic run(input logic [1:0] m, input logic v, input logic [PIX_W-1:0] fl,
                     input bit hold, input int poke_cyc);
    int cyc, exp_done, exp_err;
    exp_done = v ? 2*N + RL + 3 : N + 2;
    exp_err  = 0;
    if (v) for (int k = 0; k < N; k++) exp_err += int'(cor0[k]) + int'(cor1[k]);
    start = 1'b1; mode = m; verify = v; fill = fl;
    cyc = 0;
    while (cyc < exp_done + 8) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk("start_clr_error", error, 0);
        chk("start_clr_errcnt", err_count, 0);
        chk("done_one_cycle", done, 0);
      end
      chk("busy", busy, 64'(cyc < exp_done));
      chk("wr0", mem0.wr, 64'(cyc <= N));
      chk("wr1", mem1.wr, 64'(cyc <= N));
      if (cyc <= N) begin
        chk("waddr0", mem0.addr, model_addr(cyc-1));
        chk("waddr1", mem1.addr, model_addr(cyc-1));
        chk("wdata0", mem0.write, model_word(m, fl, cyc-1));
        chk("wdata1", mem1.write, model_word(m, fl, cyc-1));
      end else if (v && cyc <= 2*N) begin
        chk("raddr0", mem0.addr, model_addr(cyc-N-1));
        chk("raddr1", mem1.addr, model_addr(cyc-N-1));
      end
      if (!hold) begin
        start  = (cyc == poke_cyc);
        mode   = 2'($urandom);
        verify = 1'($urandom);
        fill   = PIX_W'($urandom);
      end
      if (done) break;
    end
    chk("done_cycle", cyc, exp_done);
    chk("error_end", error, 64'(exp_err != 0));
    chk("err_count_end", err_count, exp_err);
  endtask

  initial begin
    clear_cor();
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_wr0", mem0.wr, 0);
    chk("rst_wr1", mem1.wr, 0);
    chk("rst_addr", mem0.addr, 0);
    chk("rst_wdata", mem0.write, 0);
    reset = 1'b1;
    @(negedge clock);

    // checkerboard, no verify; word 1 all ones, word 0 zero
    chk("model_w0", model_word(2'd0, '0, 0), 36'h0);
    chk("model_w1", model_word(2'd0, '0, 1), 36'hFFFFFFFFF);
    run(2'd0, 1'b0, PIX_W'($urandom), 1'b0, 0);

    // address mode with verify, clean memory
    run(2'd3, 1'b1, '0, 1'b0, 0);

    // verify with bank1 bad at 5 and both banks bad at 9
    cor1[5] = 1'b1; cor0[9] = 1'b1; cor1[9] = 1'b1;
    run(2'd3, 1'b1, '0, 1'b0, 0);
    repeat (4) @(negedge clock);
    chk("sticky_error", error, 1);
    chk("sticky_errcnt", err_count, 3);
    clear_cor();

    // solid fill, verified
    run(2'd1, 1'b1, 18'h2A5A5, 1'b0, 0);

    // randomized runs with random corruption and an ignored mid-run start
    for (int i = 0; i < 6; i++) begin
      clear_cor();
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        cor0[$urandom_range(0, N-1)] = 1'b1;
        cor1[$urandom_range(0, N-1)] = 1'b1;
      end
      run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), PIX_W'($urandom),
          1'b0, int'($urandom_range(2, N)));
    end
    clear_cor();

    // reset while writing word 10
    start = 1'b1; mode = 2'd2; verify = 1'b0; fill = '0;
    repeat (11) @(negedge clock);
    chk("pre_rst_addr", mem0.addr, model_addr(10));
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_wr0", mem0.wr, 0);
    chk("mid_rst_wr1", mem1.wr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", mem0.addr, 0);
    reset = 1'b1;
    @(negedge clock);
    run(2'($urandom_range(0, 3)), 1'b0, PIX_W'($urandom), 1'b0, 0);

    // start held high: back-to-back runs, error cleared only by the new run
    cor0[3] = 1'b1;
    run(2'd2, 1'b1, '0, 1'b1, 0);
    clear_cor();
    run(2'd2, 1'b1, '0, 1'b1, 0);
    start = 1'b0;
    @(negedge clock);
    chk("final_done_low", done, 0);
    chk("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
